// File: rtl/buzzer_pkg.sv
// Shared types and field widths for the buzzer scheduler and its arbiter.
package buzzer_pkg;

    localparam int NUM_REQ = 4;
    localparam int BEEP_W  = 3;
    localparam int SPEED_W = 2;
    localparam int PTR_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
    import buzzer_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // The 2-bit index add wraps naturally, giving the circular search order.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buzzer_scheduler.sv
// Shares one active-low buzzer among four requesters, playing each winner's
// beep pattern (count and phase length captured at grant) to completion.
module buzzer_scheduler #(
    parameter int COUNT_MAX = 25000000,
    parameter int NUM_REQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] beeps,
    input  logic [2*NUM_REQ-1:0] speed,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 buzzer
);

    import buzzer_pkg::*;

    localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [CNT_W-1:0]   len_m1, len_m1_next;
    logic [BEEP_W-1:0]  beeps_left, beeps_left_next;
    logic [NUM_REQ-1:0] owner, owner_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [NUM_REQ-1:0] winner;
    logic [PTR_W-1:0]   win_idx;
    logic [BEEP_W-1:0]  win_beeps;
    logic [SPEED_W-1:0] win_speed;

    // Phase length is held as L-1 so the counter never needs to reach COUNT_MAX.
    function automatic logic [CNT_W-1:0] len_minus_one(input logic [SPEED_W-1:0] s);
        int shifted;
        shifted = COUNT_MAX >> s;
        if (shifted <= 1) begin
            return '0;
        end
        return CNT_W'(shifted - 1);
    endfunction

    rr_arbiter u_arbiter (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

    assign win_idx   = onehot_to_idx(winner);
    assign win_beeps = beeps[win_idx*BEEP_W +: BEEP_W];
    assign win_speed = speed[win_idx*SPEED_W +: SPEED_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            len_m1     <= '0;
            beeps_left <= '0;
            owner      <= '0;
            ptr        <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            len_m1     <= len_m1_next;
            beeps_left <= beeps_left_next;
            owner      <= owner_next;
            ptr        <= ptr_next;
        end
    end

    // Outputs decode from registered state only, so reset silences the buzzer at once.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        len_m1_next     = len_m1;
        beeps_left_next = beeps_left;
        owner_next      = owner;
        ptr_next        = ptr;
        buzzer          = 1'b1;
        grant           = '0;
        done            = '0;
        busy            = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_next      = ON;
                    owner_next      = winner;
                    cnt_next        = '0;
                    len_m1_next     = len_minus_one(win_speed);
                    beeps_left_next = (win_beeps == '0) ? BEEP_W'(1) : win_beeps;
                end
            end
            ON: begin
                buzzer = 1'b0;
                grant  = owner;
                busy   = 1'b1;
                if (cnt == len_m1) begin
                    cnt_next   = '0;
                    state_next = OFF;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            OFF: begin
                grant = owner;
                busy  = 1'b1;
                if (cnt == len_m1) begin
                    cnt_next = '0;
                    if (beeps_left > BEEP_W'(1)) begin
                        beeps_left_next = beeps_left - BEEP_W'(1);
                        state_next      = ON;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                grant      = owner;
                done       = owner;
                busy       = 1'b1;
                ptr_next   = onehot_to_idx(owner) + PTR_W'(1);
                owner_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
